// File: rtl/llc_update_sched_pkg.sv
// Shared cache types for the LLC update scheduler: the default set-index width
// and the state encoding used by the sweep FSM.
package llc_update_sched_pkg;

    localparam int LLC_SET_BITS = 9;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RST_SWEEP   = 2'd1,
        FLUSH_SWEEP = 2'd2,
        DONE        = 2'd3
    } llc_update_sched_state_t;

endpackage

// File: rtl/llc_sweep_counter.sv
// Set-index counter for LLC sweeps; flags the terminal set so the FSM can stop
// without writing a wrapped index.
module llc_sweep_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {WIDTH{1'b0}};
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = &count_q;

endmodule

// File: rtl/llc_update_sched.sv
// Arbitrates the LLC tag-array write port between normal updates and reset/flush
// sweeps, with a starvation guard so flush sweeps keep making progress.
module llc_update_sched
    import llc_update_sched_pkg::*;
#(
    parameter int SET_BITS     = LLC_SET_BITS,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_req_valid,
    output logic                rst_req_ready,
    input  logic                flush_req_valid,
    output logic                flush_req_ready,
    input  logic                upd_valid,
    output logic                upd_ready,
    output logic                sweep_wr_en,
    output logic                sweep_is_flush,
    output logic [SET_BITS-1:0] sweep_set,
    output logic                done_valid,
    input  logic                done_ready,
    output logic                busy
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    llc_update_sched_state_t state_d;
    llc_update_sched_state_t state_q;
    logic [STARVE_W-1:0]     starve_d;
    logic [STARVE_W-1:0]     starve_q;

    logic                rst_rdy_s;
    logic                flush_rdy_s;
    logic                upd_rdy_s;
    logic                wr_en_s;
    logic                is_flush_s;
    logic                done_s;
    logic                cnt_clear_s;
    logic                cnt_last_s;
    logic [SET_BITS-1:0] cnt_s;

    // Counter is held at zero outside sweeps, so every sweep starts at set 0.
    assign cnt_clear_s = (state_q == IDLE) || (state_q == DONE);

    llc_sweep_counter #(
        .WIDTH (SET_BITS)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .enable (wr_en_s),
        .clear  (cnt_clear_s),
        .count  (cnt_s),
        .last   (cnt_last_s)
    );

    // Next-state and per-state handshake/strobe decode.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        rst_rdy_s   = 1'b0;
        flush_rdy_s = 1'b0;
        upd_rdy_s   = 1'b0;
        wr_en_s     = 1'b0;
        is_flush_s  = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            IDLE: begin
                rst_rdy_s   = 1'b1;
                flush_rdy_s = ~rst_req_valid;
                upd_rdy_s   = upd_valid;
                starve_d    = {STARVE_W{1'b0}};
                if (rst_req_valid) begin
                    state_d = RST_SWEEP;
                end else if (flush_req_valid) begin
                    state_d = FLUSH_SWEEP;
                end else begin
                    state_d = IDLE;
                end
            end
            RST_SWEEP: begin
                wr_en_s = 1'b1;
                if (cnt_last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RST_SWEEP;
                end
            end
            FLUSH_SWEEP: begin
                // Updates win until STARVE_LIMIT grants in a row, then one set is forced.
                if (upd_valid && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
                    upd_rdy_s = 1'b1;
                    starve_d  = starve_q + STARVE_W'(1);
                end else begin
                    wr_en_s    = 1'b1;
                    is_flush_s = 1'b1;
                    starve_d   = {STARVE_W{1'b0}};
                    if (cnt_last_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = FLUSH_SWEEP;
                    end
                end
            end
            DONE: begin
                done_s    = 1'b1;
                upd_rdy_s = upd_valid;
                if (done_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d  = IDLE;
                starve_d = {STARVE_W{1'b0}};
            end
        endcase
    end

    // FSM and starvation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= {STARVE_W{1'b0}};
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Reset forces every output low immediately, even mid-cycle.
    assign rst_req_ready   = ~rst & rst_rdy_s;
    assign flush_req_ready = ~rst & flush_rdy_s;
    assign upd_ready       = ~rst & upd_rdy_s;
    assign sweep_wr_en     = ~rst & wr_en_s;
    assign sweep_is_flush  = ~rst & is_flush_s;
    assign sweep_set       = rst ? {SET_BITS{1'b0}} : cnt_s;
    assign done_valid      = ~rst & done_s;
    assign busy            = ~rst & (state_q != IDLE);

endmodule

// File: doc/llc_update_sched.md
LLC_UPDATE_SCHED -- requirements
Module: llc_update_sched

Interface
REQ-001 SHALL have parameter SET_BITS, default 9, meaning log2 of number of LLC sets swept.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning max consecutive update grants during a flush sweep before one sweep write is forced.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports rst_req_valid  input  1 and rst_req_ready  output  1, the reset-sweep start handshake.
REQ-006 SHALL have ports flush_req_valid  input  1 and flush_req_ready  output  1, the flush-sweep start handshake.
REQ-007 SHALL have ports upd_valid  input  1 (update FIFO non-empty) and upd_ready  output  1, the grant of the write port to a normal update (drives FIFO pop).
REQ-008 SHALL have port sweep_wr_en  output  1, sweep write strobe for one set.
REQ-009 SHALL have port sweep_is_flush  output  1, high when the sweep write is a flush (valid DATA ways only); low for a reset (all ways, evict way).
REQ-010 SHALL have port sweep_set  output  SET_BITS, the set index of the current sweep write.
REQ-011 SHALL have ports done_valid  output  1 and done_ready  input  1, the sweep-complete handshake (rst/flush tb_done).
REQ-012 SHALL have port busy  output  1, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RST_SWEEP, FLUSH_SWEEP, DONE.
REQ-014 IDLE: rst_req_ready=flush_req_ready=1, upd_ready=upd_valid; rst_req_valid -> RST_SWEEP; else flush_req_valid -> FLUSH_SWEEP; both high same cycle -> RST_SWEEP, flush held unaccepted (flush_req_ready=0 that cycle).
REQ-015 On sweep entry, the set counter SHALL be 0 and the starve counter SHALL be 0.
REQ-016 RST_SWEEP: upd_ready=0; sweep_wr_en=1 every cycle; sweep_is_flush=0.
REQ-017 FLUSH_SWEEP: if upd_valid and starve counter < STARVE_LIMIT, upd_ready=1, sweep_wr_en=0, starve counter +1; otherwise sweep_wr_en=1, sweep_is_flush=1, upd_ready=0, starve counter cleared.
REQ-018 Each cycle with sweep_wr_en=1 SHALL increment the set counter by 1; sweep_set equals the counter value in that cycle.
REQ-019 A sweep write at set 2^SET_BITS-1 SHALL end the sweep, with the next state DONE and no wrap write to set 0.
REQ-020 DONE: done_valid=1, upd_ready=upd_valid, new sweep requests not accepted; done_valid&&done_ready -> IDLE next cycle.
REQ-021 Sweep latency SHALL be exactly 2^SET_BITS cycles for a reset, and 2^SET_BITS plus granted-update cycles for a flush; done_valid SHALL rise the cycle after the last sweep write.
REQ-022 upd_ready and sweep_wr_en SHALL never be high in the same cycle.
REQ-023 rst_req_valid/flush_req_valid asserted mid-sweep SHALL be ignored (ready=0) until IDLE.

Reset
REQ-024 While rst is high, the FSM SHALL be in IDLE, both counters SHALL be 0, and outputs SHALL be: sweep_wr_en=0, sweep_is_flush=0, sweep_set=0, done_valid=0, busy=0, upd_ready=0, rst_req_ready=0, flush_req_ready=0.
REQ-025 rst asserted mid-sweep SHALL abort the sweep immediately with no done_valid; after release, the block SHALL be in IDLE.

Structure
REQ-026 The state enum (llc_update_sched_state_t) SHALL live in the shared cache types package, and SET_BITS SHALL default from the shared LLC set-bits constant.
REQ-027 The set counter with its terminal-count flag SHALL be one sub-module, llc_sweep_counter (enable, clear, count, last).

Verification
REQ-028 Reset sweep, SET_BITS=3: rst_req_valid pulse in IDLE -> sweep_wr_en high 8 consecutive cycles, sweep_set 0..7, upd_ready=0 throughout, done_valid the next cycle.
REQ-029 Flush with upd_valid held high, STARVE_LIMIT=2, SET_BITS=2 -> repeating pattern of 2 update grants then 1 sweep write; 4 sweep writes total; done_valid after 12 cycles.
REQ-030 rst_req_valid and flush_req_valid high together in IDLE -> RST_SWEEP, sweep_is_flush=0; flush is accepted only after DONE->IDLE.
REQ-031 done_ready held low 5 cycles in DONE -> done_valid stays 1; upd_ready tracks upd_valid; no sweep writes.
REQ-032 rst asserted at sweep_set=3 -> all outputs 0 asynchronously; after release busy=0, and a new flush starts at set 0.
